// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, imem req/ack fetch, instruction latch, next-PC and retire counter
//
// Optional feature macro: FETCH_ILLEGAL_TRAP_EN (adds the illegal port and a terminal HALT state)
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   imem_req, imem_addr      fetch request and word address (imem_addr is pc)
//   imem_ack, imem_rdata     response strobe with same-cycle instruction word
//   retire                   pulse: current instruction finished executing
//   branch, branchnot, zero  branch controls and ALU zero, sampled on the retire cycle
//   instr, opcode, pc        latched instruction, its opcode field, its address
//   instr_valid              instr may be executed
//   retired_cnt              wrapping count of retired instructions
//   illegal                  illegal-opcode trap flag (FETCH_ILLEGAL_TRAP_EN only)
module instr_fetch_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    input  logic            retire,
    input  logic            branch,
    input  logic            branchnot,
    input  logic            zero,
    output logic [15:0]     instr,
    output logic [3:0]      opcode,
    output logic [PC_W-1:0] pc,
    output logic            instr_valid,
    output logic [15:0]     retired_cnt
`ifdef FETCH_ILLEGAL_TRAP_EN
    ,
    output logic            illegal
`endif
);

`ifdef FETCH_ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_VALID = 2'd2, S_HALT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_VALID = 2'd2} state_t;
`endif

    state_t state, state_next;

    logic            ack_take;
    logic            retire_take;
    logic            taken;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] pc_next;

`ifdef FETCH_ILLEGAL_TRAP_EN
    logic illegal_op;
    assign illegal_op = (imem_rdata[15:12] > 4'd9);
`endif

    assign imem_addr = pc;
    assign opcode    = instr[15:12];

    // Branch target is relative to pc+1; imm6 sign-extended to the PC width.
    assign br_off  = {{(PC_W-6){instr[5]}}, instr[5:0]};
    assign taken   = (branch & zero) | (branchnot & ~zero);
    assign pc_next = pc + {{(PC_W-1){1'b0}}, 1'b1} + (taken ? br_off : {PC_W{1'b0}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        ack_take    = 1'b0;
        retire_take = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ack_take = 1'b1;
`ifdef FETCH_ILLEGAL_TRAP_EN
                    state_next = illegal_op ? S_HALT : S_VALID;
`else
                    state_next = S_VALID;
`endif
                end
            end
            S_VALID: begin
                instr_valid = 1'b1;
                if (retire) begin
                    retire_take = 1'b1;
                    state_next  = S_REQ;
                end
            end
`ifdef FETCH_ILLEGAL_TRAP_EN
            S_HALT: begin
                state_next = S_HALT;
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= 16'h0000;
            retired_cnt <= 16'h0000;
`ifdef FETCH_ILLEGAL_TRAP_EN
            illegal     <= 1'b0;
`endif
        end else begin
            if (ack_take) begin
                instr <= imem_rdata;
`ifdef FETCH_ILLEGAL_TRAP_EN
                if (illegal_op) begin
                    illegal <= 1'b1;
                end
`endif
            end
            if (retire_take) begin
                retired_cnt <= retired_cnt + 16'd1;
                pc          <= pc_next;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        retire;
    logic        branch;
    logic        branchnot;
    logic        zero;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [15:0] pc;
    logic        instr_valid;
    logic [15:0] retired_cnt;
`ifdef FETCH_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    instr_fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .retire      (retire),
        .branch      (branch),
        .branchnot   (branchnot),
        .zero        (zero),
        .instr       (instr),
        .opcode      (opcode),
        .pc          (pc),
        .instr_valid (instr_valid),
        .retired_cnt (retired_cnt)
`ifdef FETCH_ILLEGAL_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: what the fetch unit should hold, from the architectural rules.
    int          m_pc;
    int          m_cnt;
    logic [15:0] m_instr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},    32'(pc),          32'h0);
        check({tag, "_instr"}, 32'(instr),       32'h0);
        check({tag, "_req"},   32'(imem_req),    32'h0);
        check({tag, "_valid"}, 32'(instr_valid), 32'h0);
        check({tag, "_cnt"},   32'(retired_cnt), 32'h0);
`ifdef FETCH_ILLEGAL_TRAP_EN
        check({tag, "_illegal"}, 32'(illegal), 32'h0);
`endif
    endtask

    // Called while in REQ: hold off `waits` cycles (optionally pulsing a stray retire), then ack `word`.
    task automatic fetch(input logic [15:0] word, input int waits, input bit spur_retire);
        for (int i = 0; i < waits; i++) begin
            retire   = spur_retire ? 1'($urandom) : 1'b0;
            imem_ack = 1'b0;
            check("wait_req",   32'(imem_req),    32'h1);
            check("wait_addr",  32'(imem_addr),   32'(m_pc));
            check("wait_valid", 32'(instr_valid), 32'h0);
            tick();
        end
        retire     = 1'b0;
        check("ack_req",  32'(imem_req),  32'h1);
        check("ack_addr", 32'(imem_addr), 32'(m_pc));
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        m_instr    = word;
        check("fetch_valid",  32'(instr_valid), 32'h1);
        check("fetch_req",    32'(imem_req),    32'h0);
        check("fetch_instr",  32'(instr),       32'(m_instr));
        check("fetch_opcode", 32'(opcode),      32'(m_instr[15:12]));
        check("fetch_pc",     32'(pc),          32'(m_pc));
        check("fetch_cnt",    32'(retired_cnt), 32'(m_cnt));
    endtask

    // Called while in VALID: a stray ack must not disturb the latched instruction.
    task automatic spurious_ack();
        imem_ack   = 1'b1;
        imem_rdata = ~m_instr;
        tick();
        imem_ack   = 1'b0;
        check("spur_ack_instr", 32'(instr),       32'(m_instr));
        check("spur_ack_valid", 32'(instr_valid), 32'h1);
    endtask

    task automatic do_retire(input bit br, input bit bn, input bit z);
        bit taken;
        int off;
        retire    = 1'b1;
        branch    = br;
        branchnot = bn;
        zero      = z;
        tick();
        retire    = 1'b0;
        branch    = 1'($urandom);
        branchnot = 1'($urandom);
        zero      = 1'($urandom);
        taken = (br && z) || (bn && !z);
        off   = m_instr[5] ? int'(m_instr[5:0]) - 64 : int'(m_instr[5:0]);
        m_pc  = (m_pc + 1 + (taken ? off : 0)) & 32'hFFFF;
        m_cnt = (m_cnt + 1) & 32'hFFFF;
        check("ret_pc",    32'(pc),          32'(m_pc));
        check("ret_addr",  32'(imem_addr),   32'(m_pc));
        check("ret_cnt",   32'(retired_cnt), 32'(m_cnt));
        check("ret_valid", 32'(instr_valid), 32'h0);
        check("ret_req",   32'(imem_req),    32'h1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        retire     = 1'b0;
        branch     = 1'b0;
        branchnot  = 1'b0;
        zero       = 1'b0;
        m_pc       = 0;
        m_cnt      = 0;
        m_instr    = 16'h0000;
        tick();
        tick();
        check_reset_outputs("reset");

        // First post-reset cycle is IDLE; an ack here is ignored.
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        check("idle_req", 32'(imem_req), 32'h0);
        tick();
        imem_ack = 1'b0;
        check("first_req",   32'(imem_req),    32'h1);
        check("first_addr",  32'(imem_addr),   32'h0);
        check("idle_ack_ig", 32'(instr),       32'h0);
        check("first_valid", 32'(instr_valid), 32'h0);

        // Zero-wait fetch of addi, then retire.
        fetch(16'h1045, 0, 1'b0);
        check("addi_opcode", 32'(opcode), 32'h1);
        do_retire(1'b0, 1'b0, 1'b0);
        check("addi_pc",  32'(pc),          32'h1);
        check("addi_cnt", 32'(retired_cnt), 32'h1);

        // Three wait states; bring pc to 0x0010 with a taken branch of +14.
        fetch(16'h800E, 3, 1'b0);
        do_retire(1'b1, 1'b0, 1'b1);
        check("pc_0010", 32'(pc), 32'h0010);

        // Branch cases at pc 0x0010 with imm6 = -2.
        fetch(16'h803E, 0, 1'b0);
        do_retire(1'b1, 1'b0, 1'b1);
        check("beq_taken", 32'(pc), 32'h000F);
        fetch(16'h0000, 1, 1'b0);
        do_retire(1'b0, 1'b0, 1'b0);
        fetch(16'h803E, 0, 1'b0);
        do_retire(1'b1, 1'b0, 1'b0);
        check("beq_not_taken", 32'(pc), 32'h0011);
        fetch(16'h803E, 0, 1'b0);
        do_retire(1'b1, 1'b1, 1'b1);
        fetch(16'h903E, 2, 1'b0);
        do_retire(1'b0, 1'b1, 1'b0);
        check("bne_taken", 32'(pc), 32'h000F);

        // Stray retire during REQ and stray ack during VALID are ignored.
        fetch(16'h2001, 3, 1'b1);
        spurious_ack();
        do_retire(1'b0, 1'b0, 1'b0);

        // Reset asserted while waiting for an ack aborts at once.
        tick();
        check("midwait_req", 32'(imem_req), 32'h1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midwait_rst");
        m_pc    = 0;
        m_cnt   = 0;
        m_instr = 16'h0000;
        tick();
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'h5555;
        check("stale_idle_req", 32'(imem_req), 32'h0);
        tick();
        imem_ack = 1'b0;
        check("stale_ack_instr", 32'(instr),       32'h0);
        check("stale_ack_valid", 32'(instr_valid), 32'h0);
        check("stale_ack_req",   32'(imem_req),    32'h1);

        // PC wrap: 0 + 1 - 2 = 0xFFFF, then 0xFFFF + 1 = 0.
        fetch(16'h803E, 0, 1'b0);
        do_retire(1'b1, 1'b0, 1'b1);
        check("pc_ffff", 32'(pc), 32'hFFFF);
        fetch(16'h3000, 1, 1'b0);
        do_retire(1'b0, 1'b0, 1'b0);
        check("pc_wrap", 32'(pc), 32'h0000);

        // Randomized instruction stream against the reference model.
        for (int n = 0; n < 40; n++) begin
            w = 16'($urandom);
`ifdef FETCH_ILLEGAL_TRAP_EN
            w[15:12] = 4'($urandom_range(0, 9));
`endif
            fetch(w, int'($urandom_range(0, 3)), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                spurious_ack();
            end
            do_retire(1'($urandom), 1'($urandom), 1'($urandom));
        end

`ifdef FETCH_ILLEGAL_TRAP_EN
        // Illegal opcode traps into HALT; nothing moves until reset.
        imem_ack   = 1'b1;
        imem_rdata = 16'hA000;
        tick();
        imem_ack = 1'b0;
        check("trap_illegal", 32'(illegal),     32'h1);
        check("trap_valid",   32'(instr_valid), 32'h0);
        check("trap_instr",   32'(instr),       32'hA000);
        check("trap_pc",      32'(pc),          32'(m_pc));
        for (int i = 0; i < 20; i++) begin
            imem_ack = 1'($urandom);
            retire   = 1'($urandom);
            tick();
            check("halt_req",     32'(imem_req),    32'h0);
            check("halt_valid",   32'(instr_valid), 32'h0);
            check("halt_illegal", 32'(illegal),     32'h1);
            check("halt_cnt",     32'(retired_cnt), 32'(m_cnt));
        end
        imem_ack = 1'b0;
        retire   = 1'b0;
`else
        // Without the trap an illegal opcode runs as a no-op.
        begin
            int prev_pc;
            prev_pc = m_pc;
            fetch(16'hA000, 0, 1'b0);
            do_retire(1'b0, 1'b0, 1'b0);
            check("illegal_noop_pc", 32'(pc), 32'((prev_pc + 1) & 32'hFFFF));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage for the 16-bit, 4-bit-opcode single-cycle core: holds the PC, requests instruction words from instruction memory over a req/ack handshake, and presents the latched instruction and its opcode to the main control decoder. It consumes the decoder's `branch`/`branchnot` outputs plus the ALU zero flag to compute the next PC. It also counts retired instructions.

## Interface
Parameters:
- `PC_W`, 16, word-address width of PC and `imem_addr`
- `RESET_PC`, 0, PC value loaded on reset

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  PC_W  word address of the request; equals `pc`
- `imem_ack`  in  1  memory response strobe; `imem_rdata` is valid in the same cycle
- `imem_rdata`  in  16  instruction word
- `retire`  in  1  one-cycle pulse from the core: current instruction has finished executing
- `branch`  in  1  beq decoded, from main control
- `branchnot`  in  1  bne decoded, from main control
- `zero`  in  1  ALU zero flag
- `instr`  out  16  latched instruction register
- `opcode`  out  4  `instr[15:12]`, drives main control
- `pc`  out  PC_W  address of `instr`
- `instr_valid`  out  1  `instr` is valid and may be executed
- `retired_cnt`  out  16  count of retired instructions
- `illegal`  out  1  illegal-opcode trap flag; present only with the macro

## Operation
- Instruction layout: `[15:12]` opcode; `[5:0]` imm6, sign-extended for branch offsets.
- Legal opcodes are 0000-1001. Opcodes 1010-1111 are illegal.
- States:
  - IDLE: after reset, lasts 1 cycle, then goes to REQ.
  - REQ: `imem_req`=1, `imem_addr`=`pc`. Stays in REQ until `imem_ack`. On ack, `instr` <= `imem_rdata` and the state goes to VALID.
  - VALID: `instr_valid`=1, `imem_req`=0. On `retire`:
    - `retired_cnt` increments; it is 16 bits and wraps from 0xFFFF to 0.
    - `taken` = (`branch` & `zero`) | (`branchnot` & ~`zero`).
    - `pc` <= `taken` ? `pc`+1+sext(imm6) : `pc`+1, mod 2^PC_W. Wrap from all-ones to 0 is legal.
    - The state goes to REQ.
  - HALT: reachable only with the macro. Terminal until reset.
- `branch`, `zero` and `branchnot` are sampled only on the `retire` cycle.
- `branch` and `branchnot` both high is treated as an OR of the two conditions.
- `imem_ack` outside REQ is ignored.
- `retire` outside VALID is ignored and does not increment the counter.
- `instr` is stable throughout VALID and changes only on an accepted ack.

## Timing
- Reset values: `pc`=`RESET_PC`, `instr`=0, `imem_req`=0, `instr_valid`=0, `retired_cnt`=0, `illegal`=0, state IDLE.
- Reset asserted mid-request or mid-VALID aborts immediately. An ack in the first post-reset cycle (IDLE) is ignored.
- First `imem_req` is asserted in the 2nd cycle after `rst` deasserts.
- Ack latency:
  - Zero-wait memory (ack in the first REQ cycle) gives `instr_valid` on the next cycle.
  - N-cycle wait gives `instr_valid` N+1 cycles after REQ entry.
- `retire` in cycle t: `instr_valid`=0 and the new `pc`/`imem_req`=1 appear in cycle t+1.
- Peak throughput: one instruction per 2 cycles.
- All outputs are registered, except:
  - `imem_addr` = `pc`
  - `opcode` = `instr[15:12]`
  - `imem_req` and `instr_valid`, which are decoded from the state register

## Configuration
- `FETCH_ILLEGAL_TRAP_EN` defined:
  - Port `illegal` exists.
  - An ack delivering an illegal opcode still latches `instr` and `pc`, but the state goes to HALT instead of VALID.
  - In HALT: `illegal`=1, `instr_valid`=0, `imem_req`=0. `retire` and `imem_ack` are ignored. Only `rst` exits.
- Not defined:
  - No `illegal` port and no HALT state.
  - Illegal opcodes go to VALID like any other opcode. Main control decodes them to all-zero controls, so they execute as no-ops and advance `pc` by 1.

## Test plan
- Reset, zero-wait memory: `imem_req` in the 2nd cycle after `rst` release with `imem_addr`=0. Ack with 0x1045 (addi) -> next cycle `instr_valid`=1, `opcode`=0001. `retire` -> `pc`=1, `retired_cnt`=1.
- Wait states: ack held off 3 cycles -> `imem_req` stays 1 with `imem_addr` stable; `instr_valid`=1 exactly 4 cycles after REQ entry.
- Branch taken/not taken: `pc`=0x0010, instr imm6=0x3E (-2):
  - `branch`=1, `zero`=1 -> `pc`=0x000F.
  - `branch`=1, `zero`=0 -> `pc`=0x0011.
  - `branchnot`=1, `zero`=0 -> `pc`=0x000F.
- Wrap and ignored events:
  - `pc`=0xFFFF with `retire` -> `pc`=0x0000.
  - `retire` pulsed during REQ -> `retired_cnt` unchanged.
  - Spurious ack during VALID -> `instr` unchanged.
- Reset mid-WAIT: `rst` pulse while `imem_req`=1 -> all outputs return to reset values at once. A stale ack in the IDLE cycle is ignored.
- With `FETCH_ILLEGAL_TRAP_EN`: ack 0xA000 -> `illegal`=1, `instr_valid`=0, no further `imem_req` over 20 cycles. Without it: `instr_valid`=1, and `retire` advances `pc` by 1.
